// File: rtl/fifo_word_packer.sv
// Packs DATASIZE-wide bytes read from a registered-output synchronous FIFO into
// DATASIZE*PACK-wide words, with an optional flush that emits a partial word.
module fifo_word_packer #(
    parameter int DATASIZE = 8,
    parameter int PACK     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATASIZE-1:0]      fifo_data_out,
    input  logic                     fifo_empty,
    output logic                     fifo_r_en,
    input  logic                     flush,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATASIZE*PACK-1:0] m_data,
    output logic [PACK-1:0]          m_keep,
    output logic                     flush_busy
);

    localparam int CW = $clog2(PACK + 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(PACK);
    localparam logic [CW:0]   PACK_WIDE = (CW + 1)'(PACK);

    logic [CW-1:0]            cnt_reg;
    logic                     pending_reg;
    logic                     flush_req_reg;
    logic                     m_valid_reg;
    logic [DATASIZE*PACK-1:0] m_data_reg;
    logic [PACK-1:0]          m_keep_reg;

    logic [DATASIZE*PACK-1:0] acc_flat;
    logic [PACK-1:0]          keep_mask;
    logic                     out_free;
    logic                     do_full;
    logic                     do_flush;
    logic                     clear_acc;
    logic                     emit;
    logic [CW-1:0]            wr_lane;

    // Reads are budgeted against bytes already held plus the one still in flight.
    assign fifo_r_en = !fifo_empty && !flush_req_reg &&
                       (({1'b0, cnt_reg} + (CW + 1)'(pending_reg)) < PACK_WIDE);

    assign out_free  = !m_valid_reg || m_ready;
    assign do_full   = (cnt_reg == CNT_FULL) && out_free;
    assign do_flush  = flush_req_reg && !pending_reg && out_free;
    assign clear_acc = do_full || do_flush;
    assign emit      = do_full || (do_flush && (cnt_reg != '0));
    assign wr_lane   = clear_acc ? '0 : cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            logic [DATASIZE-1:0] lane_reg;

            // A byte landing on the transfer edge starts the fresh word in lane 0.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (pending_reg && (wr_lane == CW'(gi))) begin
                    lane_reg <= fifo_data_out;
                end else if (clear_acc) begin
                    lane_reg <= '0;
                end
            end

            assign acc_flat[gi*DATASIZE +: DATASIZE] = lane_reg;
            assign keep_mask[gi] = (CW'(gi) < cnt_reg);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            pending_reg   <= 1'b0;
            flush_req_reg <= 1'b0;
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
            m_keep_reg    <= '0;
        end else begin
            pending_reg <= fifo_r_en;

            if (clear_acc) begin
                cnt_reg <= pending_reg ? CW'(1) : '0;
            end else if (pending_reg) begin
                cnt_reg <= cnt_reg + CW'(1);
            end

            if (emit) begin
                m_data_reg  <= acc_flat;
                m_keep_reg  <= keep_mask;
                m_valid_reg <= 1'b1;
            end else if (m_valid_reg && m_ready) begin
                m_valid_reg <= 1'b0;
            end

            if (do_flush) begin
                flush_req_reg <= 1'b0;
            end else if (flush) begin
                flush_req_reg <= 1'b1;
            end
        end
    end

    assign m_valid    = m_valid_reg;
    assign m_data     = m_data_reg;
    assign m_keep     = m_keep_reg;
    assign flush_busy = flush_req_reg;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboarded bench for fifo_word_packer: a queue-based FIFO model feeds bytes,
// a byte-grouping reference model predicts words, a negedge monitor checks them.
module tb_fifo_word_packer;

    localparam int DS = 8;
    localparam int PK = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DS-1:0] fifo_data_out = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_r_en;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DS*PK-1:0] m_data;
    logic [PK-1:0] m_keep;
    logic          flush_busy;

    typedef struct {
        logic [DS*PK-1:0] d;
        logic [PK-1:0]    k;
    } word_t;

    logic [DS-1:0] fifo_q[$];
    logic [DS-1:0] pend_q[$];
    word_t         exp_q[$];
    word_t         mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    logic          hold_v = 1'b0;
    logic [DS*PK-1:0] hold_d = '0;
    logic [PK-1:0] hold_k = '0;

    fifo_word_packer #(.DATASIZE(DS), .PACK(PK)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .fifo_r_en    (fifo_r_en),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_keep       (m_keep),
        .flush_busy   (flush_busy)
    );

    always #5 clk = ~clk;

    // Upstream FIFO: registered read data, one cycle after the sampled read.
    always @(posedge clk) begin
        if (fifo_r_en) begin
            if (fifo_q.size() == 0) begin
                $display("FAIL fifo_underflow: read issued with 0 bytes stored, required at least 1");
                n_bad++;
            end else begin
                fifo_data_out <= fifo_q.pop_front();
            end
        end
    end

    // Monitor: protocol checks and scoreboard pops on each accepted word.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            n_cmp++;
            if (fifo_r_en && fifo_empty) begin
                $display("FAIL r_en_while_empty: fifo_r_en=%b with fifo_empty=%b, required fifo_r_en=0",
                         fifo_r_en, fifo_empty);
                n_bad++;
            end
            if (hold_v) begin
                n_cmp++;
                if (!m_valid || m_data !== hold_d || m_keep !== hold_k) begin
                    $display("FAIL hold_stable: got v=%b d=%h k=%b, required v=1 d=%h k=%b",
                             m_valid, m_data, m_keep, hold_d, hold_k);
                    n_bad++;
                end
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_word: got d=%h k=%b, required no word", m_data, m_keep);
                    n_bad++;
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_data !== mon_e.d || m_keep !== mon_e.k) begin
                        $display("FAIL word: got d=%h k=%b, required d=%h k=%b",
                                 m_data, m_keep, mon_e.d, mon_e.k);
                        n_bad++;
                    end else begin
                        $display("word accepted d=%h k=%b", m_data, m_keep);
                    end
                end
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_k = m_keep;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            $display("FAIL %s: got %h, required %h", name, act, req);
            n_bad++;
        end
    endtask

    task automatic push_fifo(input logic [DS-1:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // Reference model: every PK bytes in arrival order form one word, first byte lowest.
    task automatic model_byte(input logic [DS-1:0] b);
        word_t w;
        pend_q.push_back(b);
        if (pend_q.size() == PK) begin
            w.d = '0;
            for (int i = 0; i < PK; i++) w.d[DS*i +: DS] = pend_q[i];
            w.k = '1;
            exp_q.push_back(w);
            pend_q.delete();
        end
    endtask

    task automatic model_flush();
        word_t w;
        int n;
        n = pend_q.size();
        if (n > 0) begin
            w.d = '0;
            for (int i = 0; i < n; i++) w.d[DS*i +: DS] = pend_q[i];
            w.k = PK'((1 << n) - 1);
            exp_q.push_back(w);
            pend_q.delete();
        end
    endtask

    task automatic feed(input logic [DS-1:0] b);
        push_fifo(b);
        model_byte(b);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
            step();
            c++;
        end
        n_cmp++;
        if (c >= budget) begin
            $display("FAIL %s_timeout: fifo=%0d words_left=%0d after %0d cycles, required 0/0",
                     name, fifo_q.size(), exp_q.size(), c);
            n_bad++;
        end
        repeat (3) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fed;

        rst_n = 1'b0;
        repeat (3) step();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_keep", 32'(m_keep), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_flush_busy", 32'(flush_busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Eight preloaded bytes, downstream always ready.
        for (int b = 1; b <= 8; b++) feed(DS'(b));
        wait_idle("t_two_words", 100);

        // Downstream stalled: first word must hold, reads stop after two words absorbed.
        m_ready = 1'b0;
        for (int b = 1; b <= 12; b++) feed(DS'(b));
        repeat (14) step();
        check("stall_fifo_left", 32'(fifo_q.size()), 32'd4);
        check("stall_m_valid", 32'(m_valid), 32'd1);
        check("stall_m_data", m_data, 32'h04030201);
        check("stall_r_en", 32'(fifo_r_en), 32'd0);
        m_ready = 1'b1;
        wait_idle("t_stall", 100);

        // Three bytes then flush: partial word with zero upper lane.
        feed(8'hA1);
        feed(8'hA2);
        feed(8'hA3);
        wait_idle("t_partial_fill", 100);
        model_flush();
        pulse_flush();
        check("partial_busy_set", 32'(flush_busy), 32'd1);
        check("partial_not_yet_valid", 32'(m_valid), 32'd0);
        step();
        check("partial_busy_clear", 32'(flush_busy), 32'd0);
        check("partial_valid", 32'(m_valid), 32'd1);
        check("partial_keep", 32'(m_keep), 32'h7);
        wait_idle("t_partial", 100);

        // Flush with nothing held: busy for one cycle, no word.
        pulse_flush();
        check("empty_flush_busy_set", 32'(flush_busy), 32'd1);
        step();
        check("empty_flush_busy_clear", 32'(flush_busy), 32'd0);
        check("empty_flush_no_valid", 32'(m_valid), 32'd0);
        repeat (3) step();

        // Flush on the same cycle as a read: the in-flight byte joins the flushed word.
        push_fifo(8'h5A);
        push_fifo(8'h5B);
        model_byte(8'h5A);
        model_flush();
        model_byte(8'h5B);
        pulse_flush();
        wait_idle("t_inflight", 100);
        model_flush();
        pulse_flush();
        wait_idle("t_inflight_tail", 100);

        // Reset with two bytes absorbed: they must never appear.
        feed(8'hEE);
        feed(8'hEF);
        wait_idle("t_pre_reset", 100);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pend_q.delete();
        exp_q.delete();
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_busy", 32'(flush_busy), 32'd0);
        check("midrst_keep", 32'(m_keep), 32'd0);
        for (int b = 8'h11; b <= 8'h14; b++) feed(DS'(b));
        wait_idle("t_post_reset", 100);

        // Randomised rounds: random byte arrival and downstream backpressure.
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(5, 23));
            fed = 0;
            while (fed < n) begin
                if ($urandom_range(0, 9) < 6) begin
                    feed(DS'($urandom));
                    fed++;
                end
                m_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            m_ready = 1'b1;
            wait_idle("t_rand", 400);
            if (pend_q.size() > 0) begin
                model_flush();
                pulse_flush();
                wait_idle("t_rand_flush", 100);
            end
        end

        check("final_words_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
